avalon_mem_bridge: RTL

//  Avalon-MM bridge between mips_cpu_bus (bus master) and RAM_32x64k_avalon (slave).

---
 rtl/avalon_mem_bridge.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/avalon_mem_bridge.sv
// avalon_mem_bridge
//   Avalon-MM bridge between a CPU bus master and a 32x64k RAM slave.
//   Checks that the CPU byte address lies in [BASE_ADDR, BASE_ADDR+WINDOW_BYTES-1],
//   is word aligned and is not a simultaneous read+write, then translates it into
//   the RAM's local window. Legal accesses are stalled for a programmable number
//   of cycles (fixed or LFSR-driven) before being forwarded. Illegal accesses are
//   answered locally with zero read data and recorded in a sticky error flag.
//   Only one transaction is outstanding at a time.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   s_address         CPU byte address
//   s_read/s_write    CPU read/write request
//   s_writedata       CPU write data
//   s_byteenable      CPU byte lanes
//   s_waitrequest     stall to CPU (combinational)
//   s_readdata        read data to CPU, valid when s_read & !s_waitrequest
//   m_address         translated address (s_address - BASE_ADDR)
//   m_read/m_write    RAM read/write strobes
//   m_writedata       registered copy of s_writedata
//   m_byteenable      registered copy of s_byteenable
//   m_waitrequest     RAM stall
//   m_readdata        RAM read data
//   bus_err           sticky: illegal access or protocol violation since reset
//   err_addr          address of the first error
//   rd_count/wr_count completed legal reads/writes (wrapping)

module avalon_mem_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
  parameter logic [31:0] WINDOW_BYTES = 32'h00010000,
  parameter int unsigned WAIT_MODE    = 0,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + WINDOW_BYTES - 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    FWD,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        req;
  logic        illegal;
  logic [3:0]  load_cnt;
  logic [3:0]  stall_cnt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic        is_write;
  logic        err_txn;
  logic [31:0] rdata_q;

  assign req = s_read | s_write;

  always_comb begin
    illegal = 1'b0;
    if (s_read && s_write)         illegal = 1'b1;
    if (s_address[1:0] != 2'b00)   illegal = 1'b1;
    if (s_address < BASE_ADDR)     illegal = 1'b1;
    if (s_address > LAST_ADDR)     illegal = 1'b1;
  end

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    load_cnt = 4'(WAIT_CYCLES);
    if (WAIT_MODE == 1) load_cnt = {1'b0, lfsr[2:0]};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and bus outputs
  always_comb begin
    state_nxt     = state;
    s_waitrequest = req && (state != RESP);
    m_read        = 1'b0;
    m_write       = 1'b0;
    s_readdata    = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal)             state_nxt = RESP;
          else if (load_cnt == '0) state_nxt = FWD;
          else                     state_nxt = STALL;
        end
      end
      STALL: begin
        if (!req)                   state_nxt = IDLE;
        else if (stall_cnt == 4'd1) state_nxt = FWD;
      end
      FWD: begin
        m_read  = !is_write;
        m_write = is_write;
        if (!m_waitrequest) state_nxt = RESP;
      end
      RESP: begin
        if (!err_txn && !is_write) s_readdata = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, error capture and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      stall_cnt    <= '0;
      lfsr         <= LFSR_SEED;
      is_write     <= 1'b0;
      err_txn      <= 1'b0;
      rdata_q      <= '0;
      bus_err      <= 1'b0;
      err_addr     <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_write <= s_write;
            err_txn  <= illegal;
            if (illegal) begin
              if (!bus_err) begin
                bus_err  <= 1'b1;
                err_addr <= s_address;
              end
            end else begin
              // RAM-facing registers only change for legal accesses
              m_address    <= s_address - BASE_ADDR;
              m_writedata  <= s_writedata;
              m_byteenable <= s_byteenable;
              stall_cnt    <= load_cnt;
              lfsr         <= lfsr_nxt;
            end
          end
        end
        STALL: begin
          if (!req) begin
            // CPU abandoned a stalled request; its address is recovered
            // from the translated copy held in m_address.
            if (!bus_err) begin
              bus_err  <= 1'b1;
              err_addr <= m_address + BASE_ADDR;
            end
          end else begin
            stall_cnt <= stall_cnt - 4'd1;
          end
        end
        FWD: begin
          if (!m_waitrequest && !is_write) rdata_q <= m_readdata;
        end
        RESP: begin
          if (!err_txn) begin
            if (is_write) wr_count <= wr_count + 16'd1;
            else          rd_count <= rd_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
